// File: rtl/dpb_stream_pkg.sv
// dpb_stream_pkg: shared constants and state encoding for the DPB byte-stream
// reader.
//   RAM_BYTES   : size of the dual-port block RAM in bytes
//   DPB_ADDR_W  : default RAM address width
//   DPB_DATA_W  : default RAM and stream data width
//   state_t     : reader FSM states
package dpb_stream_pkg;

   localparam int RAM_BYTES  = 4096;
   localparam int DPB_ADDR_W = $clog2(RAM_BYTES);
   localparam int DPB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/dpb_stream_fifo.sv
// dpb_stream_fifo: small shift-style synchronous FIFO whose head entry is the
// output register, so valid and dout come straight from flops.
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : drop all entries (wins over push)
//   push, din   : write one entry; caller guarantees the FIFO is not full
//                 unless a pop happens in the same cycle
//   pop         : consume the head entry (only while valid)
//   valid, dout : head entry
//   count       : number of stored entries
module dpb_stream_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] dout,
   output logic [CW-1:0]     count
);

   logic [DEPTH-1:0][DATA_W-1:0] mem, mem_n;
   logic [CW-1:0]                count_n, wr_idx;

   always_comb begin
      // The write slot sits after the surviving entries, so a pop in the same
      // cycle moves it one place toward the head.
      wr_idx  = count - CW'(pop);
      count_n = count + CW'(push) - CW'(pop);
      mem_n   = mem;
      if (pop)
         for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      if (push)
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == wr_idx) mem_n[i] = din;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem   <= '0;
         count <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         count <= '0;
         valid <= 1'b0;
      end else begin
         mem   <= mem_n;
         count <= count_n;
         valid <= (count_n != '0);
      end
   end

   assign dout = mem[0];

endmodule

// File: rtl/dpb_stream_reader.sv
// dpb_stream_reader: streams a contiguous byte range out of RAM port A as a
// valid/ready byte stream. Reads are issued only when a FIFO slot is
// guaranteed for the returning byte, which hides the one-cycle RAM latency
// and keeps one byte per clock under continuous m_ready.
//   clk, resetn                 : clock (shared with RAM clka), async low reset
//   start, base_addr, length    : request, sampled only in IDLE
//   abort                       : cancel any transfer, no done pulse
//   busy, done                  : status; done pulses after the final handshake
//   ram_ce/oce/wre/ad, ram_dout : RAM port A
//   m_valid, m_data, m_ready    : output byte stream
module dpb_stream_reader
   import dpb_stream_pkg::*;
#(
   parameter int ADDR_W = DPB_ADDR_W,
   parameter int DATA_W = DPB_DATA_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              ram_ce,
   output logic              ram_oce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   issue_left, recv_left;
   logic              inflight;
   logic              pop, last_pop;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit;

   assign pop      = m_valid & m_ready;
   assign last_pop = pop && (recv_left == (ADDR_W+1)'(1));

   // Occupancy the FIFO will have after this edge, before any new issue.
   // pop implies fifo_count >= 1, so this never underflows.
   assign credit = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);

   // Gating with abort keeps inflight clear on the cycle the FIFO flushes.
   assign ram_ce  = (state == RUN) && (issue_left != '0) && !abort &&
                    (credit < (CW+1)'(DEPTH));
   assign ram_ad  = addr;
   assign ram_oce = 1'b1;
   assign ram_wre = 1'b0;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         addr       <= '0;
         issue_left <= '0;
         recv_left  <= '0;
         inflight   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= ram_ce;
         if (abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (length == '0) begin
                        done <= 1'b1;
                     end else begin
                        state      <= RUN;
                        addr       <= base_addr;
                        issue_left <= length;
                        recv_left  <= length;
                     end
                  end
               end
               RUN, DRAIN: begin
                  if (ram_ce) begin
                     addr       <= addr + 1'b1;   // wraps modulo RAM size
                     issue_left <= issue_left - 1'b1;
                  end
                  if (pop) recv_left <= recv_left - 1'b1;
                  if (last_pop) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else if (state == RUN && ram_ce &&
                               issue_left == (ADDR_W+1)'(1)) begin
                     state <= DRAIN;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   dpb_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (abort),
      .push   (inflight),
      .din    (ram_dout),
      .pop    (pop),
      .valid  (m_valid),
      .dout   (m_data),
      .count  (fifo_count)
   );

endmodule

// File: tb/tb_dpb_stream_reader.sv
module tb_dpb_stream_reader;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [11:0] base_addr;
   logic [12:0] length;
   logic        abort;
   logic        busy, done;
   logic        ram_ce, ram_oce, ram_wre;
   logic [11:0] ram_ad;
   logic [7:0]  ram_dout = 8'h00;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready;

   dpb_stream_reader dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .ram_ce    (ram_ce),
      .ram_oce   (ram_oce),
      .ram_wre   (ram_wre),
      .ram_ad    (ram_ad),
      .ram_dout  (ram_dout),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready)
   );

   always #5 clk = ~clk;

   // RAM port A model: registered read, bypass mode
   logic [7:0] ram [4096];
   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'((i * 7) ^ (i >> 5));
      ram[0] = 8'hEA; ram[1] = 8'hCE; ram[2] = 8'hB0; ram[3] = 8'h3F;
   end
   always @(posedge clk) if (ram_ce) ram_dout <= ram[ram_ad];

   int n_chk = 0, n_pass = 0;
   logic [7:0]  exp_q [$];
   logic [11:0] ad_log [$];
   int rx_cnt = 0, done_cnt = 0, ce_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // monitor / scoreboard
   initial begin
      int cyc = 0, last_pop_cyc = 0, pops_sd = 0, issued = 0, popped = 0;
      logic prev_v = 1'b0, prev_r = 1'b0, prev_ab = 1'b0;
      logic [7:0] prev_d = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetn) begin
            prev_v = 1'b0; issued = 0; popped = 0; pops_sd = 0;
         end else begin
            if (done) begin
               done_cnt++;
               if (pops_sd > 0) begin
                  chk("done_timing", cyc - last_pop_cyc, 1);
                  chk("done_drained", exp_q.size(), 0);
               end
               pops_sd = 0;
            end else if (!busy) pops_sd = 0;
            if (prev_v && !prev_r && !prev_ab) begin
               chk("hold_valid", m_valid, 1);
               chk("hold_data", m_data, prev_d);
            end
            if (m_valid && m_ready) begin
               rx_cnt++; pops_sd++; last_pop_cyc = cyc;
               if (exp_q.size() == 0) chk("extra_byte", 1, 0);
               else chk("stream_data", m_data, exp_q.pop_front());
            end
            if (ram_ce) begin
               ce_total++;
               ad_log.push_back(ram_ad);
            end
            if (busy) begin
               issued += int'(ram_ce);
               popped += int'(m_valid && m_ready);
               if (ram_ce) chk("credit", (issued - popped) <= 2, 1);
            end else begin
               issued = 0; popped = 0;
            end
            prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_ab = abort;
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic go(input logic [11:0] b, input logic [12:0] l);
      start = 1'b1; base_addr = b; length = l;
      for (int i = 0; i < int'(l); i++) exp_q.push_back(ram[12'(int'(b) + i)]);
   endtask

   task automatic wait_done(input int d0, input int maxc, input string nm);
      int n = 0;
      while (done_cnt == d0 && n < maxc) begin tick; n++; end
      chk({nm, "_timeout"}, done_cnt != d0, 1);
      tick;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ram_ce"}, ram_ce, 0);
      chk({tag, "_ram_wre"}, ram_wre, 0);
      chk({tag, "_ram_oce"}, ram_oce, 1);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_ram_ad"}, ram_ad, 0);
      chk({tag, "_m_data"}, m_data, 0);
   endtask

   initial begin
      int rx0, d0, ce0, n;
      resetn = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
      base_addr = '0; length = '0;
      tick; tick;
      chk_reset("rst");
      resetn = 1'b1;
      tick;

      // basic read, latency and throughput
      rx0 = rx_cnt;
      go(12'h000, 13'd4);
      tick;                                   // E0
      start = 1'b0;
      chk("basic_ce", ram_ce, 1);
      chk("basic_ad", ram_ad, 12'h000);
      chk("basic_busy", busy, 1);
      tick;                                   // E1
      chk("basic_lat_v0", m_valid, 0);
      tick;                                   // E2
      chk("basic_lat_v1", m_valid, 1);
      chk("basic_byte0", m_data, 8'hEA);
      repeat (4) tick;                        // E6
      chk("basic_count", rx_cnt - rx0, 4);
      chk("basic_done", done, 1);
      tick;
      chk("basic_done_low", done, 0);
      chk("basic_idle", busy, 0);

      // zero length
      go(12'h010, 13'd0);
      tick;
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_ce", ram_ce, 0);
      chk("zero_busy", busy, 0);
      tick;
      chk("zero_done_low", done, 0);

      // address wrap
      ad_log.delete();
      d0 = done_cnt;
      go(12'hFFE, 13'd4);
      tick; start = 1'b0;
      wait_done(d0, 50, "wrap");
      chk("wrap_nreads", ad_log.size(), 4);
      if (ad_log.size() == 4) begin
         chk("wrap_ad0", ad_log[0], 12'hFFE);
         chk("wrap_ad1", ad_log[1], 12'hFFF);
         chk("wrap_ad2", ad_log[2], 12'h000);
         chk("wrap_ad3", ad_log[3], 12'h001);
      end

      // random backpressure
      d0 = done_cnt;
      go(12'h200, 13'd16);
      tick; start = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         m_ready = 1'($urandom_range(0, 1));
         tick; n++;
      end
      m_ready = 1'b1;
      chk("bp_timeout", done_cnt != d0, 1);
      chk("bp_drained", exp_q.size(), 0);
      tick;

      // start while busy is ignored
      d0 = done_cnt; ce0 = ce_total;
      go(12'h300, 13'd8);
      tick; start = 1'b0;
      tick; tick;
      start = 1'b1; base_addr = 12'h500; length = 13'd3;
      tick; start = 1'b0;
      wait_done(d0, 50, "ign");
      chk("ign_reads", ce_total - ce0, 8);
      chk("ign_done_once", done_cnt - d0, 1);
      chk("ign_drained", exp_q.size(), 0);

      // full 4096-byte range
      d0 = done_cnt; ce0 = ce_total;
      go(12'h123, 13'h1000);
      tick; start = 1'b0;
      wait_done(d0, 5000, "full");
      chk("full_reads", ce_total - ce0, 4096);
      chk("full_done_once", done_cnt - d0, 1);
      chk("full_drained", exp_q.size(), 0);

      // abort after 5 of 10 bytes
      rx0 = rx_cnt;
      go(12'h040, 13'd10);
      tick; start = 1'b0;
      n = 0;
      while (rx_cnt - rx0 < 5 && n < 50) begin tick; n++; end
      chk("abort_wait", rx_cnt - rx0, 5);
      m_ready = 1'b0; abort = 1'b1;
      d0 = done_cnt;
      tick;
      abort = 1'b0;
      chk("abort_idle", busy, 0);
      chk("abort_valid", m_valid, 0);
      chk("abort_ce", ram_ce, 0);
      exp_q.delete();
      m_ready = 1'b1;
      repeat (3) tick;
      chk("abort_no_done", done_cnt - d0, 0);

      // clean run after abort
      d0 = done_cnt;
      go(12'h000, 13'd3);
      tick; start = 1'b0;
      wait_done(d0, 50, "post_abort");
      chk("post_abort_drained", exp_q.size(), 0);

      // reset mid-transfer
      go(12'h080, 13'd10);
      tick; start = 1'b0;
      m_ready = 1'b0;
      repeat (3) tick;
      chk("pre_rst_valid", m_valid, 1);
      resetn = 1'b0;
      #1;
      chk_reset("midrst");
      exp_q.delete();
      tick;
      resetn = 1'b1; m_ready = 1'b1;
      tick;

      chk("final_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
